crypto1_key_sched: RTL and testbench
====================================

# crypto1_key_sched

Run controller and result arbiter for a bank of Crypto1 key-recovery cores. It latches a 48-bit keystream, holds the cores in reset while they load, then starts them together. It collects candidate keys from all cores through a round-robin arbiter into a FIFO, and signals completion once every core has finished and the FIFO has drained. It sits between the host/register interface and the `NCORES` core instances.

## Interface
Parameters:
- `NCORES`, 4: number of attached cores, 2..16.
- `FIFO_DEPTH`, 8: candidate-key FIFO entries; must be a power of 2, minimum 2.

Ports:
- `CLK`  in  1  single clock; all logic on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `START`  in  1  one-cycle pulse; begins a run; ignored unless IDLE.
- `ABORT`  in  1  one-cycle pulse; ends any run and returns to IDLE.
- `BITSTREAM`  in  48  keystream; sampled on the START cycle.
- `CORE_BITSTREAM`  out  48  latched keystream broadcast to all cores.
- `CORE_RESETn`  out  1  active-low core reset; low whenever not RUN.
- `CORE_KEY`  in  NCORES*48  candidate keys; core i uses bits [48i+47:48i].
- `CORE_VALID`  in  NCORES  per-core candidate valid.
- `CORE_READY`  out  NCORES  one-hot grant; at most one bit high per cycle.
- `CORE_DONE`  in  NCORES  per-core level: search exhausted.
- `KEY_DATA`  out  48  FIFO head key.
- `KEY_SRC`  out  $clog2(NCORES)  index of the core that produced `KEY_DATA`.
- `KEY_VALID`  out  1  FIFO non-empty.
- `KEY_READY`  in  1  downstream accept.
- `BUSY`  out  1  high in any state except IDLE.
- `DONE`  out  1  one-cycle completion pulse.
- `KEY_COUNT`  out  16  candidates accepted this run (see Configuration).

## Operation
- **States:** IDLE, LOAD, RUN, DRAIN, FINISH.
- **IDLE**
  - START=1: latch BITSTREAM into `CORE_BITSTREAM`, clear done-sticky bits, clear KEY_COUNT, go to LOAD.
- **LOAD**
  - Holds exactly 2 cycles with `CORE_RESETn`=0, then goes to RUN.
  - `CORE_RESETn` rises on the first RUN cycle.
- **RUN**
  - Sticky `done_seen[i]` is set when `CORE_DONE[i]`=1.
  - All `done_seen` bits set and `CORE_VALID`==0 in the same cycle → DRAIN.
- **DRAIN**
  - No grants are issued.
  - FIFO empty → FINISH.
- **FINISH**
  - DONE=1 for one cycle, then IDLE.
- **Arbiter**
  - Operates in RUN only, and only when the FIFO is not full.
  - Grants the first requesting core at or after `rr_ptr`, with modulo-NCORES wrap.
  - Grant is combinational in the same cycle: `CORE_READY[g]`=1, and that key plus index g are written to the FIFO at the clock edge.
  - `rr_ptr` ← (g+1) mod NCORES after each grant; it is unchanged when nothing is granted.
- **FIFO full**
  - All `CORE_READY`=0, even if a read occurs in the same cycle.
  - A full-with-read cycle therefore writes nothing.
- **FIFO read:** KEY_VALID && KEY_READY pops the head.
- **Simultaneous read and write** (not full): both take effect; occupancy is unchanged.
- **ABORT** (any non-IDLE state)
  - Flushes the FIFO and drives `CORE_RESETn`=0 from the next cycle.
  - Goes to IDLE, with no DONE pulse.
  - ABORT takes precedence over START.
- **RESET**
  - Drives: state IDLE, FIFO empty, `rr_ptr`=0, `CORE_BITSTREAM`=0, `CORE_RESETn`=0, `CORE_READY`=0.
  - Also drives: KEY_DATA=0, KEY_SRC=0, KEY_VALID=0, BUSY=0, DONE=0, KEY_COUNT=0.

## Timing
- START at cycle t:
  - BUSY=1 at t+1.
  - LOAD occupies t+1..t+2.
  - RUN starts at t+3, with `CORE_RESETn`=1 from t+3.
- Key granted at cycle t → KEY_VALID=1 and KEY_DATA valid at t+1.
  - Registered FIFO storage, no fall-through.
- Peak sustained throughput: one key per cycle across all cores.
- Last core done at t with no pending valids → DRAIN at t+1.
- FIFO empties at cycle e → FINISH, DONE=1 at e+1, and BUSY=0 at e+2.
- KEY_DATA and KEY_SRC are held stable while KEY_VALID=1 and KEY_READY=0.

## Configuration
- `CRYPTO1_SCHED_KEY_COUNT_EN` defined:
  - KEY_COUNT increments on every FIFO write.
  - It saturates at 0xFFFF and is cleared on START.
- `CRYPTO1_SCHED_KEY_COUNT_EN` not defined:
  - KEY_COUNT is constant 0 and no counter logic is generated.
  - All other behaviour is identical.

## Structure
- The shared package `crypto1_pkg` holds:
  - `CRYPTO1_KEY_W` = 48.
  - `crypto1_sched_state_t` (enum logic [2:0]: IDLE, LOAD, RUN, DRAIN, FINISH).
  - `CRYPTO1_LOAD_CYCLES` = 2.
- Sub-module `crypto1_key_fifo`:
  - Synchronous FIFO, width `CRYPTO1_KEY_W` + $clog2(NCORES), depth FIFO_DEPTH.
  - Provides full, empty, flush, and occupancy counter.
- The arbiter and FSM live in the top module.

## Test plan
- **Basic run:** NCORES=4, START with BITSTREAM=48'hA5A5_0F0F_1234.
  - Expect CORE_BITSTREAM matches, `CORE_RESETn` low for 2 cycles then high, BUSY=1.
- **Round-robin:** all 4 cores hold VALID with keys 48'h1..48'h4, KEY_READY=1.
  - Expect KEY_SRC sequence 0,1,2,3,0 and exactly one READY bit per cycle.
- **Backpressure:** KEY_READY=0, core 2 streams keys.
  - Expect 8 accepts, then READY=0; FIFO order is preserved when KEY_READY rises.
- **Completion:** all CORE_DONE asserted with 3 keys queued.
  - Expect no DONE until the 3rd pop; then DONE is a single-cycle pulse and BUSY falls one cycle later.
- **Abort:** ABORT mid-RUN with 5 keys queued.
  - Expect KEY_VALID=0 next cycle, `CORE_RESETn`=0, state IDLE, no DONE.
- **Count saturation** (macro defined): force 70000 accepts.
  - Expect KEY_COUNT=0xFFFF; the next START clears it to 0.

Source files
------------

// File: rtl/crypto1_pkg.sv
// rtl/crypto1_pkg.sv - shared constants and state type for the Crypto1 key scheduler
package crypto1_pkg;
    localparam int CRYPTO1_KEY_W       = 48;
    localparam int CRYPTO1_LOAD_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        FINISH
    } crypto1_sched_state_t;
endpackage

// File: rtl/crypto1_key_fifo.sv
// rtl/crypto1_key_fifo.sv - synchronous candidate-key FIFO with flush and occupancy count
module crypto1_key_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    // Head reads as zero when empty so the outputs are clean straight out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/crypto1_key_sched.sv
// rtl/crypto1_key_sched.sv - run controller and round-robin key arbiter for Crypto1 cores
// Optional candidate counter on KEY_COUNT: define CRYPTO1_SCHED_KEY_COUNT_EN
module crypto1_key_sched
    import crypto1_pkg::*;
#(
    parameter int NCORES     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              START,
    input  logic                              ABORT,
    input  logic [CRYPTO1_KEY_W-1:0]          BITSTREAM,
    output logic [CRYPTO1_KEY_W-1:0]          CORE_BITSTREAM,
    output logic                              CORE_RESETn,
    input  logic [NCORES*CRYPTO1_KEY_W-1:0]   CORE_KEY,
    input  logic [NCORES-1:0]                 CORE_VALID,
    output logic [NCORES-1:0]                 CORE_READY,
    input  logic [NCORES-1:0]                 CORE_DONE,
    output logic [CRYPTO1_KEY_W-1:0]          KEY_DATA,
    output logic [$clog2(NCORES)-1:0]         KEY_SRC,
    output logic                              KEY_VALID,
    input  logic                              KEY_READY,
    output logic                              BUSY,
    output logic                              DONE,
    output logic [15:0]                       KEY_COUNT
);
    localparam int IDX_W = $clog2(NCORES);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = CRYPTO1_KEY_W + IDX_W;

    crypto1_sched_state_t     state;
    logic [1:0]               load_cnt;
    logic [NCORES-1:0]        done_seen;
    logic [NCORES-1:0]        done_all;
    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         grant_idx;
    logic [IDX_W:0]           cand;
    logic                     grant_any;
    logic [CRYPTO1_KEY_W-1:0] grant_key;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         fifo_count;
    logic [ENT_W-1:0]         fifo_rdata;

    assign done_all = done_seen | CORE_DONE;

    // First requester at or after rr_ptr, wrapping modulo NCORES.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (state == RUN && !fifo_full) begin
            for (int k = 0; k < NCORES; k++) begin
                cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(NCORES)) cand = cand - (IDX_W+1)'(NCORES);
                if (!grant_any && CORE_VALID[cand[IDX_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = cand[IDX_W-1:0];
                end
            end
        end
    end

    always_comb begin
        CORE_READY = '0;
        grant_key  = '0;
        if (grant_any) CORE_READY[grant_idx] = 1'b1;
        for (int k = 0; k < NCORES; k++) begin
            if (grant_idx == IDX_W'(k)) grant_key = CORE_KEY[k*CRYPTO1_KEY_W +: CRYPTO1_KEY_W];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == IDX_W'(NCORES-1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    crypto1_key_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .reset   (RESET),
        .flush   (ABORT),
        .wr_en   (grant_any),
        .wr_data ({grant_idx, grant_key}),
        .rd_en   (KEY_READY),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign KEY_VALID = !fifo_empty;
    assign KEY_DATA  = fifo_rdata[CRYPTO1_KEY_W-1:0];
    assign KEY_SRC   = fifo_rdata[ENT_W-1:CRYPTO1_KEY_W];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= IDLE;
            load_cnt       <= '0;
            done_seen      <= '0;
            CORE_BITSTREAM <= '0;
            CORE_RESETn    <= 1'b0;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
        end else if (ABORT) begin
            state       <= IDLE;
            CORE_RESETn <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    state          <= LOAD;
                    CORE_BITSTREAM <= BITSTREAM;
                    done_seen      <= '0;
                    load_cnt       <= '0;
                    BUSY           <= 1'b1;
                end
                LOAD: if (load_cnt == 2'(CRYPTO1_LOAD_CYCLES-1)) begin
                    state       <= RUN;
                    CORE_RESETn <= 1'b1;
                end else begin
                    load_cnt <= load_cnt + 2'd1;
                end
                RUN: begin
                    done_seen <= done_all;
                    if (&done_all && CORE_VALID == '0) begin
                        state       <= DRAIN;
                        CORE_RESETn <= 1'b0;
                    end
                end
                DRAIN: if (fifo_count == '0) begin
                    state <= FINISH;
                    DONE  <= 1'b1;
                end
                FINISH: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CRYPTO1_SCHED_KEY_COUNT_EN
    logic [15:0] key_count;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            key_count <= '0;
        end else if (state == IDLE && START && !ABORT) begin
            key_count <= '0;
        end else if (grant_any && key_count != 16'hFFFF) begin
            key_count <= key_count + 16'd1;
        end
    end

    assign KEY_COUNT = key_count;
`else
    assign KEY_COUNT = '0;
`endif
endmodule

// File: tb/tb_crypto1_key_sched.sv
// tb/tb_crypto1_key_sched.sv - randomized bench for crypto1_key_sched against a queue-based model
module tb_crypto1_key_sched;
    localparam int NCORES     = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int IW         = 2;
    localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_DRAIN = 3, S_FINISH = 4;

    logic                   clk = 1'b0;
    logic                   reset, start, abort, key_ready;
    logic [47:0]            bitstream;
    logic [NCORES*48-1:0]   core_key;
    logic [NCORES-1:0]      core_valid, core_done;
    logic [47:0]            core_bitstream, key_data;
    logic                   core_resetn, key_valid, busy, done;
    logic [NCORES-1:0]      core_ready;
    logic [IW-1:0]          key_src;
    logic [15:0]            key_count;

    typedef struct {
        int          src;
        logic [47:0] key;
    } entry_t;

    entry_t            m_q[$];
    int                m_state, m_load, m_rr, m_count;
    logic [NCORES-1:0] m_done;
    logic [47:0]       m_bits;
    int                n_checks = 0;
    int                n_pass   = 0;

    crypto1_key_sched #(
        .NCORES     (NCORES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .CLK            (clk),
        .RESET          (reset),
        .START          (start),
        .ABORT          (abort),
        .BITSTREAM      (bitstream),
        .CORE_BITSTREAM (core_bitstream),
        .CORE_RESETn    (core_resetn),
        .CORE_KEY       (core_key),
        .CORE_VALID     (core_valid),
        .CORE_READY     (core_ready),
        .CORE_DONE      (core_done),
        .KEY_DATA       (key_data),
        .KEY_SRC        (key_src),
        .KEY_VALID      (key_valid),
        .KEY_READY      (key_ready),
        .BUSY           (busy),
        .DONE           (done),
        .KEY_COUNT      (key_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [47:0] rand48();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[47:0];
    endfunction

    function automatic int exp_grant();
        if (m_state != S_RUN || m_q.size() >= FIFO_DEPTH) return -1;
        for (int k = 0; k < NCORES; k++) begin
            if (core_valid[(m_rr + k) % NCORES]) return (m_rr + k) % NCORES;
        end
        return -1;
    endfunction

    // Compare this cycle's outputs with the model, then advance the model across the edge.
    task automatic step_model();
        int                g;
        bit                was_empty;
        logic [NCORES-1:0] exp_ready;
        logic [NCORES-1:0] nd;
        logic [15:0]       exp_cnt;
        if (reset) begin
            m_q.delete();
            m_state = S_IDLE; m_load = 0; m_rr = 0; m_count = 0; m_done = '0; m_bits = '0;
            return;
        end
        g = exp_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        was_empty = (m_q.size() == 0);
`ifdef CRYPTO1_SCHED_KEY_COUNT_EN
        exp_cnt = 16'(m_count);
`else
        exp_cnt = 16'h0;
`endif
        chk("busy", busy, m_state != S_IDLE);
        chk("done", done, m_state == S_FINISH);
        chk("core_resetn", core_resetn, m_state == S_RUN);
        chk("core_bitstream", core_bitstream, m_bits);
        chk("key_valid", key_valid, !was_empty);
        chk("key_data", key_data, was_empty ? 48'h0 : m_q[0].key);
        chk("key_src", key_src, was_empty ? 0 : m_q[0].src);
        chk("core_ready", core_ready, exp_ready);
        chk("key_count", key_count, exp_cnt);

        if (!was_empty && key_ready) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back('{src: g, key: core_key[48*g +: 48]});
            m_rr = (g + 1) % NCORES;
            if (m_count < 65535) m_count++;
        end
        if (abort) begin
            m_q.delete();
            m_state = S_IDLE;
        end else begin
            case (m_state)
                S_IDLE: if (start) begin
                    m_bits = bitstream; m_done = '0; m_count = 0; m_load = 0; m_state = S_LOAD;
                end
                S_LOAD: begin
                    m_load++;
                    if (m_load == 2) m_state = S_RUN;
                end
                S_RUN: begin
                    nd = m_done | core_done;
                    m_done = nd;
                    if (&nd && core_valid == '0) m_state = S_DRAIN;
                end
                S_DRAIN: if (was_empty) m_state = S_FINISH;
                default: m_state = S_IDLE;
            endcase
        end
    endtask

    task automatic cycle();
        #4;
        step_model();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while (m_state != S_IDLE && k < limit) begin
            cycle();
            k++;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    task automatic begin_run(input logic [47:0] bits);
        bitstream = bits;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (2) cycle();
    endtask

    initial begin
        int n, abort_at;
        reset = 1'b1; start = 1'b0; abort = 1'b0; key_ready = 1'b0;
        bitstream = '0; core_key = '0; core_valid = '0; core_done = '0;
        @(posedge clk); #1;
        repeat (3) cycle();
        reset = 1'b0;
        repeat (2) cycle();

        begin_run(48'hA5A5_0F0F_1234);
        chk("basic_bitstream", core_bitstream, 48'hA5A5_0F0F_1234);

        for (int i = 0; i < NCORES; i++) core_key[48*i +: 48] = 48'(i + 1);
        core_valid = '1;
        key_ready  = 1'b1;
        repeat (10) cycle();
        core_valid = '0;
        repeat (4) cycle();

        // Single streaming core against a stalled consumer: fills, then must stop granting.
        key_ready  = 1'b0;
        core_valid = 4'b0100;
        for (int c = 0; c < 12; c++) begin
            core_key[96 +: 48] = rand48();
            cycle();
        end
        core_valid = '0;
        key_ready  = 1'b1;
        repeat (10) cycle();

        key_ready  = 1'b0;
        core_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            core_key[0 +: 48] = rand48();
            cycle();
        end
        core_valid = '0;
        core_done  = '1;
        repeat (4) cycle();
        key_ready = 1'b1;
        wait_idle(20);
        core_done = '0;

        begin_run(rand48());
        key_ready  = 1'b0;
        core_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            core_key[0 +: 48] = rand48();
            cycle();
        end
        core_valid = '0;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort_key_valid", key_valid, 1'b0);
        chk("abort_resetn", core_resetn, 1'b0);
        repeat (3) cycle();

        for (int r = 0; r < 8; r++) begin
            begin_run(rand48());
            n = $urandom_range(40, 150);
            abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(5, n - 1) : -1;
            for (int c = 0; c < n; c++) begin
                core_valid = NCORES'($urandom());
                for (int i = 0; i < NCORES; i++) core_key[48*i +: 48] = rand48();
                key_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) core_done[$urandom_range(0, NCORES - 1)] = 1'b1;
                start = ($urandom_range(0, 20) == 0);
                abort = (c == abort_at);
                if (abort) core_valid = '0;
                cycle();
                start = 1'b0;
                abort = 1'b0;
                if (c == abort_at) break;
            end
            core_valid = '0;
            core_done  = '1;
            key_ready  = 1'b1;
            wait_idle(60);
            core_done = '0;
        end

`ifdef CRYPTO1_SCHED_KEY_COUNT_EN
        begin_run(rand48());
        core_valid = '1;
        key_ready  = 1'b1;
        repeat (70000) cycle();
        chk("key_count_sat", key_count, 16'hFFFF);
        core_valid = '0;
        core_done  = '1;
        wait_idle(40);
        core_done = '0;
        bitstream = rand48();
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("key_count_clear", key_count, 16'h0);
        core_done = '1;
        repeat (3) cycle();
        wait_idle(40);
        core_done = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
